// File: rtl/svm_pkg.sv
// Shared types and sizing helpers for the SVM decision accumulator.
// Build option SVM_ACC_SAT_EN selects saturating accumulation in svm_decision_acc.
package svm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StBias,
    StOut
  } state_e;

  localparam int unsigned DefXlenPixel = 8;
  localparam int unsigned DP_W         = 4 * DefXlenPixel;
  localparam int unsigned MaxAccW      = 128;

  function automatic int unsigned dp_width(input int unsigned xlen_pixel);
    return 4 * xlen_pixel;
  endfunction

  function automatic int unsigned sv_cnt_width(input int unsigned num_sv);
    return $clog2(num_sv + 1);
  endfunction

  // Largest positive two's-complement value of width w, zero-padded to MaxAccW.
  function automatic logic [MaxAccW-1:0] sat_max(input int unsigned w);
    return (MaxAccW'(1) << (w - 1)) - MaxAccW'(1);
  endfunction

  // Most negative two's-complement value of width w, sign-extended to MaxAccW.
  function automatic logic [MaxAccW-1:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/svm_mac_stage.sv
// One-stage registered signed multiply of an unsigned dot product by a signed alpha.
// prod_valid marks the cycle in which prod holds a freshly accepted beat's product.
module svm_mac_stage
  import svm_pkg::*;
#(
  parameter int unsigned DpW    = DP_W,
  parameter int unsigned AlphaW = 16,
  parameter int unsigned ProdW  = DpW + 1 + AlphaW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DpW-1:0]          dp_data,
  input  logic [AlphaW-1:0]       alpha_in,
  output logic                    prod_valid,
  output logic signed [ProdW-1:0] prod
);

  logic signed [ProdW-1:0] dp_ext;
  logic signed [ProdW-1:0] alpha_ext;
  logic signed [ProdW-1:0] prod_d;

  // dp_data is unsigned: prepend a zero so the signed product is exact.
  assign dp_ext    = ProdW'($signed({1'b0, dp_data}));
  assign alpha_ext = ProdW'($signed(alpha_in));
  assign prod_d    = dp_ext * alpha_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid <= 1'b0;
      prod       <= '0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid) begin
        prod <= prod_d;
      end
    end
  end

endmodule

// File: rtl/svm_decision_acc.sv
// Weighted sum of NUM_SV dot products plus bias, producing an SVM score and class bit.
// Define SVM_ACC_SAT_EN for sticky saturating accumulation; otherwise arithmetic wraps.
module svm_decision_acc
  import svm_pkg::*;
#(
  parameter int unsigned XLEN_PIXEL = 8,
  parameter int unsigned ALPHA_W    = 16,
  parameter int unsigned ACC_W      = 56,
  parameter int unsigned NUM_SV     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ALPHA_W-1:0]      bias_in,
  input  logic                    dp_valid,
  output logic                    dp_ready,
  input  logic [4*XLEN_PIXEL-1:0] dp_data,
  input  logic [ALPHA_W-1:0]      alpha_in,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [ACC_W-1:0]        score,
  output logic                    class_out,
  output logic                    busy
);

  localparam int unsigned DpW   = dp_width(XLEN_PIXEL);
  localparam int unsigned ProdW = DpW + 1 + ALPHA_W;
  localparam int unsigned CntW  = sv_cnt_width(NUM_SV);

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [ALPHA_W-1:0]      bias_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] score_q;
  logic                    class_q;
  logic                    result_valid_q;

  logic                    beat;
  logic                    prod_valid;
  logic signed [ProdW-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] score_next;

  assign dp_ready     = (state_q == StAccum);
  assign busy         = (state_q != StIdle);
  assign beat         = dp_valid && dp_ready;
  assign result_valid = result_valid_q;
  assign score        = score_q;
  assign class_out    = class_q;

  svm_mac_stage #(
    .DpW    (DpW),
    .AlphaW (ALPHA_W),
    .ProdW  (ProdW)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (beat),
    .dp_data    (dp_data),
    .alpha_in   (alpha_in),
    .prod_valid (prod_valid),
    .prod       (prod)
  );

  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(bias_q));

`ifdef SVM_ACC_SAT_EN
  localparam logic [MaxAccW-1:0]   AccMaxWide = sat_max(ACC_W);
  localparam logic [MaxAccW-1:0]   AccMinWide = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0] AccMax = AccMaxWide[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] AccMin = AccMinWide[ACC_W-1:0];

  logic             sat_q;
  logic [ACC_W:0]   acc_wide;
  logic [ACC_W:0]   score_wide;
  logic             acc_ovf;
  logic             score_ovf;

  // One guard bit: overflow iff the top two bits of the widened sum disagree.
  assign acc_wide   = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign score_wide = {acc_q[ACC_W-1], acc_q} + {bias_ext[ACC_W-1], bias_ext};
  assign acc_ovf    = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
  assign score_ovf  = score_wide[ACC_W] ^ score_wide[ACC_W-1];

  always_comb begin
    acc_next = acc_wide[ACC_W-1:0];
    if (sat_q) begin
      acc_next = acc_q;
    end else if (acc_ovf) begin
      acc_next = acc_wide[ACC_W] ? AccMin : AccMax;
    end
  end

  // Once the sum has clamped, the bias cannot pull it back into range.
  always_comb begin
    score_next = score_wide[ACC_W-1:0];
    if (sat_q) begin
      score_next = acc_q;
    end else if (score_ovf) begin
      score_next = score_wide[ACC_W] ? AccMin : AccMax;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      sat_q <= 1'b0;
    end else if (prod_valid && acc_ovf) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign acc_next   = acc_q + prod_ext;
  assign score_next = acc_q + bias_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      bias_q         <= '0;
      acc_q          <= '0;
      score_q        <= '0;
      class_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            acc_q   <= '0;
            bias_q  <= bias_in;
          end
        end
        StAccum: begin
          if (prod_valid) begin
            acc_q <= acc_next;
          end
          if (beat) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(NUM_SV - 1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // The last beat's product lands in prod on the edge that entered this state.
          if (prod_valid) begin
            acc_q <= acc_next;
          end
          state_q <= StBias;
        end
        StBias: begin
          score_q <= score_next;
          class_q <= ~score_next[ACC_W-1];
          state_q <= StOut;
        end
        StOut: begin
          if (!result_valid_q) begin
            result_valid_q <= 1'b1;
          end else if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
